// File: rtl/dpu_core.sv
// -----------------------------------------------------------------------------
// dpu_core
//   Data processing unit placed directly downstream of the SRAM controller.
//   It accepts one command at a time. On a load it latches the opcode and
//   drives the SRAM address. It takes the operand word on the first
//   requst_valid, computes the result in a single EXEC cycle, and holds the
//   result for the controller's write-back cycle (the second requst_valid).
//
//   Timing relative to a load at cycle T:
//     address valid at T+1, operand sampled at T+3,
//     result registered at the end of T+4 (valid at T+5),
//     write-back at T+5, dpu_done pulses at T+6.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   dpu_load_cmd        1-cycle strobe: nxt_cmd carries a DPU command
//   nxt_cmd[7:0]        [7]=1, [6:5]=opcode, [4:0]=SRAM address
//   requst_valid        1st pulse: operand valid; 2nd pulse: write-back
//   sram_data_to_dpu    operand word from the SRAM controller
//   err_clr             clears protocol_err (a same-cycle new error wins)
//   sram_addr_from_dpu  registered target address, held until the next load
//   sram_data_from_dpu  registered result word, held until the next load
//   dpu_busy            high from the cycle after load until write-back completes
//   dpu_done            1-cycle pulse in the cycle after write-back
//   protocol_err        sticky flag for illegal strobe sequences
// -----------------------------------------------------------------------------
module dpu_core #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dpu_load_cmd,
  input  logic [7:0]        nxt_cmd,
  input  logic              requst_valid,
  input  logic [DATA_W-1:0] sram_data_to_dpu,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] sram_addr_from_dpu,
  output logic [DATA_W-1:0] sram_data_from_dpu,
  output logic              dpu_busy,
  output logic              dpu_done,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_OP = 2'd1,
    S_EXEC    = 2'd2,
    S_WAIT_WB = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_INC   = 2'd0,
    OP_NOT   = 2'd1,
    OP_BSWAP = 2'd2,
    OP_ACC   = 2'd3
  } op_t;

  state_t              r_state;
  state_t              w_next_state;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_acc;
  logic                r_done;
  logic                r_err;

  logic                w_accept_load;
  logic                w_capture_op;
  logic                w_exec;
  logic                w_wb_done;
  logic                w_err_set;
  logic [DATA_W-1:0]   w_bswap;
  logic [DATA_W-1:0]   w_result;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  //   An illegal strobe never changes the state; it only raises w_err_set.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_accept_load = 1'b0;
    w_capture_op  = 1'b0;
    w_exec        = 1'b0;
    w_wb_done     = 1'b0;
    w_err_set     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (requst_valid) w_err_set = 1'b1;
        if (dpu_load_cmd) begin
          w_accept_load = 1'b1;
          w_next_state  = S_WAIT_OP;
          // A command with bit7 clear still runs but is flagged.
          if (!nxt_cmd[7]) w_err_set = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (dpu_load_cmd) w_err_set = 1'b1;
        if (requst_valid) begin
          w_capture_op = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dpu_load_cmd || requst_valid) w_err_set = 1'b1;
        w_exec       = 1'b1;
        w_next_state = S_WAIT_WB;
      end
      S_WAIT_WB: begin
        if (dpu_load_cmd) w_err_set = 1'b1;
        if (requst_valid) begin
          w_wb_done    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result computation (all arithmetic wraps modulo 2^DATA_W)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bswap = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      w_bswap[8*b +: 8] = r_operand[DATA_W-8-8*b +: 8];
    end
  end

  always_comb begin
    w_result = '0;
    unique case (r_op)
      OP_INC:   w_result = r_operand + DATA_W'(1);
      OP_NOT:   w_result = ~r_operand;
      OP_BSWAP: w_result = w_bswap;
      OP_ACC:   w_result = r_acc + r_operand;
      default:  w_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  //   Address and result are intentionally not cleared on return to IDLE;
  //   the controller may still sample them until the next load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_INC;
      r_addr    <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_acc     <= ACC_INIT;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_wb_done;
      if (w_accept_load) begin
        r_op   <= op_t'(nxt_cmd[6:5]);
        r_addr <= nxt_cmd[ADDR_W-1:0];
      end
      if (w_capture_op) r_operand <= sram_data_to_dpu;
      if (w_exec) begin
        r_result <= w_result;
        if (r_op == OP_ACC) r_acc <= w_result;
      end
      // A new error takes priority over a same-cycle clear.
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign sram_addr_from_dpu = r_addr;
  assign sram_data_from_dpu = r_result;
  assign dpu_busy           = (r_state != S_IDLE);
  assign dpu_done           = r_done;
  assign protocol_err       = r_err;

endmodule
